// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, initiator FSM states and the
// response record handed back to the command side.
package axi_lite_pkg;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_EXOKAY   = 2'b01;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;
   localparam logic [1:0]  RESP_DECERR   = 2'b11;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_RSP     = 3'd5,
      ST_DRAIN   = 3'd6
   } init_state_e;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } rsp_t;

   function automatic rsp_t timeout_rsp();
      rsp_t r;
      r.rdata   = TIMEOUT_RDATA;
      r.resp    = RESP_SLVERR;
      r.timeout = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI-Lite initiator: turns one command into one AXI
// transaction, with a wait timeout that aborts cleanly by draining late handshakes.
module axi_lite_initiator #(
   parameter int AXI_ADDR_BW_p    = 12,
   parameter int TIMEOUT_CYCLES_p = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic                     i_cmd_write,
   input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
   input  logic [31:0]              i_cmd_wdata,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [31:0]              o_rsp_rdata,
   output logic [1:0]               o_rsp_resp,
   output logic                     o_rsp_timeout,
   output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
   output logic                     o_axi_awvalid,
   input  logic                     i_axi_awready,
   output logic [31:0]              o_axi_wdata,
   output logic                     o_axi_wvalid,
   input  logic                     i_axi_wready,
   input  logic [1:0]               i_axi_bresp,
   input  logic                     i_axi_bvalid,
   output logic                     o_axi_bready,
   output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
   output logic                     o_axi_arvalid,
   input  logic                     i_axi_arready,
   input  logic [31:0]              i_axi_rdata,
   input  logic [1:0]               i_axi_rresp,
   input  logic                     i_axi_rvalid,
   output logic                     o_axi_rready
);
   import axi_lite_pkg::*;

   localparam int                      CNT_W     = $clog2(TIMEOUT_CYCLES_p + 1);
   localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(TIMEOUT_CYCLES_p);
   localparam logic [AXI_ADDR_BW_p-1:0] WORD_MASK = ~AXI_ADDR_BW_p'(3);

   init_state_e              state_q, state_d;
   logic                     cmd_ready_q, cmd_ready_d;
   logic [AXI_ADDR_BW_p-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic                     awvalid_q, awvalid_d;
   logic                     wvalid_q, wvalid_d;
   logic                     arvalid_q, arvalid_d;
   logic                     bready_q, bready_d;
   logic                     rready_q, rready_d;
   logic                     b_pend_q, b_pend_d;
   logic                     r_pend_q, r_pend_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     rsp_valid_q, rsp_valid_d;
   rsp_t                     rsp_q, rsp_d;

   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic wait_st, to_hit;

   assign aw_hs   = awvalid_q & i_axi_awready;
   assign w_hs    = wvalid_q  & i_axi_wready;
   assign ar_hs   = arvalid_q & i_axi_arready;
   assign b_hs    = bready_q  & i_axi_bvalid;
   assign r_hs    = rready_q  & i_axi_rvalid;
   assign wait_st = state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
   assign to_hit  = wait_st && (cnt_q == CNT_MAX);

   // NOTE: every *_d gets its default first, so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      awvalid_d   = awvalid_q & ~aw_hs;
      wvalid_d    = wvalid_q  & ~w_hs;
      arvalid_d   = arvalid_q & ~ar_hs;
      b_pend_d    = b_pend_q  & ~b_hs;
      r_pend_d    = r_pend_q  & ~r_hs;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;

      if (wait_st && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid && cmd_ready_q) begin
               addr_d  = i_cmd_addr & WORD_MASK;
               wdata_d = i_cmd_wdata;
               cnt_d   = '0;
               if (i_cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  b_pend_d  = 1'b1;
                  state_d   = ST_WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  r_pend_d  = 1'b1;
                  state_d   = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (to_hit) begin
               rsp_d       = timeout_rsp();
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else if (!awvalid_d && !wvalid_d) begin
               state_d = ST_WR_RESP;
            end
         end
         // A real response arriving on the timeout cycle takes priority.
         ST_WR_RESP: begin
            if (b_hs) begin
               rsp_d       = '{rdata: 32'h0, resp: i_axi_bresp, timeout: 1'b0};
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else if (to_hit) begin
               rsp_d       = timeout_rsp();
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            if (to_hit) begin
               rsp_d       = timeout_rsp();
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else if (ar_hs) begin
               state_d = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (r_hs) begin
               rsp_d       = '{rdata: i_axi_rdata, resp: i_axi_rresp, timeout: 1'b0};
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else if (to_hit) begin
               rsp_d       = timeout_rsp();
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = (awvalid_d || wvalid_d || arvalid_d || b_pend_d || r_pend_d)
                             ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!(awvalid_d || wvalid_d || arvalid_d || b_pend_d || r_pend_d)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // After a timeout, bready/rready stay up so late responses are swallowed.
      cmd_ready_d = (state_d == ST_IDLE);
      bready_d    = b_pend_d && (state_d inside {ST_WR_RESP, ST_RSP, ST_DRAIN});
      rready_d    = r_pend_d && (state_d inside {ST_RD_RESP, ST_RSP, ST_DRAIN});
   end

   // NOTE: state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         b_pend_q    <= 1'b0;
         r_pend_q    <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         b_pend_q    <= b_pend_d;
         r_pend_q    <= r_pend_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign o_cmd_ready   = cmd_ready_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_rdata   = rsp_q.rdata;
   assign o_rsp_resp    = rsp_q.resp;
   assign o_rsp_timeout = rsp_q.timeout;
   assign o_axi_awaddr  = addr_q;
   assign o_axi_awvalid = awvalid_q;
   assign o_axi_wdata   = wdata_q;
   assign o_axi_wvalid  = wvalid_q;
   assign o_axi_bready  = bready_q;
   assign o_axi_araddr  = addr_q;
   assign o_axi_arvalid = arvalid_q;
   assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench for axi_lite_initiator: a scripted slave, a response scoreboard
// checked every cycle, and literal expectations for timing and timeout behaviour.
module tb_axi_lite_initiator;

   localparam int AW = 12;
   localparam int TO = 8;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } exp_rsp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0]   cmd_wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
   logic [1:0]    bresp = '0, rresp = '0;
   logic          bvalid = 1'b0, rvalid = 1'b0;
   logic [31:0]   rdata = '0;

   logic          cmd_ready, rsp_valid, rsp_timeout;
   logic [31:0]   rsp_rdata, axi_wdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] axi_awaddr, axi_araddr;
   logic          axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;

   int            vectors = 0;
   int            errors  = 0;
   exp_rsp_t      exp_q[$];
   logic [AW-1:0] exp_addr = '0;
   logic [31:0]   exp_wdata = '0;

   axi_lite_initiator #(.AXI_ADDR_BW_p(AW), .TIMEOUT_CYCLES_p(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
      .o_axi_awaddr(axi_awaddr), .o_axi_awvalid(axi_awvalid), .i_axi_awready(awready),
      .o_axi_wdata(axi_wdata), .o_axi_wvalid(axi_wvalid), .i_axi_wready(wready),
      .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(axi_bready),
      .o_axi_araddr(axi_araddr), .o_axi_arvalid(axi_arvalid), .i_axi_arready(arready),
      .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(axi_rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected response from the rules: timeout wins over everything, writes return no data.
   function automatic exp_rsp_t model_rsp(bit wr, logic [31:0] rd, logic [1:0] code, bit timed_out);
      exp_rsp_t r;
      if (timed_out) r = '{32'hDEADDEAD, 2'b10, 1'b1};
      else if (wr)   r = '{32'h0, code, 1'b0};
      else           r = '{rd, code, 1'b0};
      return r;
   endfunction

   // Per-cycle compare: AXI payloads while valid, response payload against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (axi_awvalid) check("awaddr", 32'(axi_awaddr), 32'(exp_addr));
         if (axi_wvalid)  check("wdata", axi_wdata, exp_wdata);
         if (axi_arvalid) check("araddr", 32'(axi_araddr), 32'(exp_addr));
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
               check("rsp_resp", 32'(rsp_resp), 32'(exp_q[0].resp));
               check("rsp_timeout", 32'(rsp_timeout), 32'(exp_q[0].timeout));
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      exp_addr  = a & ~AW'(3);
      exp_wdata = d;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(input int hold);
      check("rsp_valid_up", 32'(rsp_valid), 32'h1);
      for (int i = 0; i < hold; i++) begin
         check("cmd_ready_busy", 32'(cmd_ready), 32'h0);
         check("rsp_valid_hold", 32'(rsp_valid), 32'h1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid), 32'h0);
      check("cmd_ready_back", 32'(cmd_ready), 32'h1);
   endtask

   // Cycle c after accept: a valid is still up while c <= its slave latency.
   task automatic run_write(input logic [AW-1:0] a, input logic [31:0] d, input int aw_lat,
                            input int w_lat, input int b_lat, input logic [1:0] code, input int hold);
      int last = (aw_lat > w_lat) ? aw_lat : w_lat;
      exp_q.push_back(model_rsp(1'b1, 32'h0, code, 1'b0));
      send_cmd(1'b1, a, d);
      for (int c = 0; c <= last; c++) begin
         check("awvalid", 32'(axi_awvalid), 32'(c <= aw_lat));
         check("wvalid", 32'(axi_wvalid), 32'(c <= w_lat));
         check("bready_early", 32'(axi_bready), 32'h0);
         awready = (c == aw_lat);
         wready  = (c == w_lat);
         tick();
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int c = 0; c <= b_lat; c++) begin
         check("awvalid_done", 32'(axi_awvalid), 32'h0);
         check("wvalid_done", 32'(axi_wvalid), 32'h0);
         check("bready", 32'(axi_bready), 32'h1);
         bvalid = (c == b_lat);
         bresp  = code;
         tick();
      end
      bvalid = 1'b0;
      check("bready_after", 32'(axi_bready), 32'h0);
      finish_rsp(hold);
   endtask

   task automatic run_read(input logic [AW-1:0] a, input logic [31:0] rd, input logic [1:0] code,
                           input int ar_lat, input int r_lat, input int hold);
      exp_q.push_back(model_rsp(1'b0, rd, code, 1'b0));
      send_cmd(1'b0, a, 32'h0);
      for (int c = 0; c <= ar_lat; c++) begin
         check("arvalid", 32'(axi_arvalid), 32'h1);
         check("rready_early", 32'(axi_rready), 32'h0);
         arready = (c == ar_lat);
         tick();
      end
      arready = 1'b0;
      for (int c = 0; c <= r_lat; c++) begin
         check("arvalid_done", 32'(axi_arvalid), 32'h0);
         check("rready", 32'(axi_rready), 32'h1);
         rvalid = (c == r_lat);
         rdata  = rd;
         rresp  = code;
         tick();
      end
      rvalid = 1'b0;
      finish_rsp(hold);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, rsp_valid}, 32'h0);
      check("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'h0);
      check("rst_rsp_hi", {rsp_rdata[31:30], rsp_timeout}, 32'h0);
      rst_n = 1'b1;
      tick();
      check("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);

      run_write(12'h004, 32'h1234_5678, 0, 0, 0, 2'b00, 0);  // both channels same cycle
      run_write(12'h013, 32'hA5A5_0001, 3, 0, 1, 2'b00, 0);  // W three cycles ahead of AW
      run_write(12'h100, 32'h0F0F_0F0F, 1, 0, 0, 2'b01, 2);
      run_read (12'h008, 32'hCAFE_F00D, 2'b10, 0, 0, 0);
      run_read (12'h00D, 32'h0BAD_BEEF, 2'b01, 2, 1, 5);     // response held off 5 cycles
      run_write(12'hFFC, 32'hFFFF_FFFF, 0, 0, 7, 2'b11, 0);  // B lands on the timeout cycle

      // Read timeout: arready never comes until after the abort
      exp_q.push_back(model_rsp(1'b0, 32'h0, 2'b00, 1'b1));
      send_cmd(1'b0, 12'h020, 32'h0);
      for (int c = 0; c <= TO; c++) begin
         check("to_wait_rsp", 32'(rsp_valid), 32'h0);
         check("to_wait_arvalid", 32'(axi_arvalid), 32'h1);
         tick();
      end
      check("to_rsp_valid", 32'(rsp_valid), 32'h1);
      check("to_rsp_rdata", rsp_rdata, 32'hDEADDEAD);
      check("to_rsp_resp", 32'(rsp_resp), 32'h2);
      check("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
      check("to_rready", 32'(axi_rready), 32'h1);
      tick();
      check("to_arvalid_hold", 32'(axi_arvalid), 32'h1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("drain_cmd_ready", 32'(cmd_ready), 32'h0);
      check("drain_arvalid", 32'(axi_arvalid), 32'h1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("drain_ar_done", 32'(axi_arvalid), 32'h0);
      check("drain_wait_r", 32'(cmd_ready), 32'h0);
      tick();
      rvalid = 1'b1;
      rdata  = 32'h1111_1111;
      rresp  = 2'b00;
      tick();
      rvalid = 1'b0;
      check("drain_cmd_ready_back", 32'(cmd_ready), 32'h1);
      check("drain_no_rsp", 32'(rsp_valid), 32'h0);

      // Reset in the middle of a write abandons it
      send_cmd(1'b1, 12'h040, 32'h5555_AAAA);
      check("mid_awvalid", 32'(axi_awvalid), 32'h1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_valids", {axi_awvalid, axi_wvalid, axi_bready, rsp_valid, cmd_ready}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);

      run_read(12'h7F0, 32'h600D_F00D, 2'b00, 1, 0, 0);
      repeat (3) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
